// File: rtl/instr_loader.sv
// instr_loader: boot loader packing a byte stream (N, 4N LE payload bytes[, XOR checksum if LOADER_CHECKSUM_EN]) into instruction-memory word writes, holding the core until done
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);
  typedef enum logic [2:0] {
    HDR, DATA, WRITE, DONE
`ifdef LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t LAST = CHK;
`else
  localparam state_t LAST = DONE;
`endif
  state_t st, nxt;
  logic [8:0] n, idx;
  logic [1:0] cnt;
  logic [31:0] asm_word;
  logic xfer;
  assign xfer = in_valid && in_ready;
  assign wr_addr = BASE_ADDR + {21'd0, idx, 2'b00};
  assign wr_data = asm_word;
  always_ff @(posedge clk) st <= rst ? HDR : nxt;
  always_comb begin
    nxt = st;
    case (st)
      HDR:   nxt = xfer ? DATA : HDR;
      DATA:  nxt = xfer && cnt == 2'd3 ? WRITE : DATA;
      WRITE: nxt = idx + 9'd1 == n ? LAST : DATA;
`ifdef LOADER_CHECKSUM_EN
      CHK:   nxt = xfer ? DONE : CHK;
`endif
      default: nxt = st;
    endcase
  end
  always_comb begin
    in_ready  = !rst && st != WRITE && st != DONE;
    wr_en     = !rst && st == WRITE;
    cpu_hold  = rst || st != DONE;
    load_done = !rst && st == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      n        <= '0;
      idx      <= '0;
      cnt      <= '0;
      asm_word <= '0;
    end else begin
      if (xfer && st == HDR) begin
        n   <= in_data == 8'd0 ? 9'd256 : {1'b0, in_data};
        idx <= '0;
        cnt <= '0;
      end
      if (xfer && st == DATA) begin
        asm_word[8*cnt +: 8] <= in_data;
        cnt <= cnt + 2'd1;
      end
      if (st == WRITE) idx <= idx + 9'd1;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic err;
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      if (xfer && st == HDR) csum <= '0;
      if (xfer && st == DATA) csum <= csum ^ in_data;
      if (xfer && st == CHK) err <= in_data != csum;
    end
  end
  assign load_err = err;
`else
  assign load_err = 1'b0;
`endif
endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader that fills the instruction memory from a byte stream before the core starts fetching. It accepts bytes over a valid/ready handshake, assembles them little-endian into 32-bit instruction words, and drives a word-aligned write port into the instruction bank. It holds the program counter in reset (`cpu_hold`) until the image is fully written. It is the write-side counterpart of the instruction-fetch path.

## Interface
- `BASE_ADDR`, default 32'd0: byte address of the first instruction word written.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle (transfer = `in_valid & in_ready`).
- `wr_en` output 1: single-cycle write strobe to instruction memory.
- `wr_addr` output 32: byte address, always a multiple of 4.
- `wr_data` output 32: assembled instruction word.
- `cpu_hold` output 1: keep the PC and core stalled while this is high.
- `load_done` output 1: image loaded (sticky until `rst`).
- `load_err` output 1: checksum mismatch (sticky until `rst`; 0 when the checksum feature is compiled out).

## Operation
- Image format: byte 0 is the word count N, where 0 means 256. This is followed by 4·N payload bytes, least-significant byte first per word. With the checksum feature, one trailing checksum byte follows.
- States:
  - HDR: `in_ready`=1. On transfer, latch N, clear the word index and byte counter, then go to DATA.
  - DATA: `in_ready`=1. On transfer, shift the byte into the assembly register at lane `byte_cnt`. When the 4th byte is accepted, go to WRITE.
  - WRITE: `in_ready`=0. Assert `wr_en` for exactly 1 cycle with `wr_addr` = `BASE_ADDR` + 4·index. Then increment index. If index = N, go to CHK (checksum build) or DONE; otherwise return to DATA.
  - CHK: `in_ready`=1. On transfer, compare the byte to the running XOR of all payload bytes, set `load_err` on mismatch, then go to DONE.
  - DONE: `in_ready`=0, `cpu_hold`=0, `load_done`=1. Further input is ignored and never acknowledged.
- Word index is 9 bits, so N=256 (header 0) completes at index 256. Addresses never wrap within an image.
- `cpu_hold` = 1 in every state except DONE.
- The header byte is not included in the checksum.

## Timing
- Reset values: state HDR, `in_ready`=0 during the reset cycle and 1 from the first cycle after `rst` deasserts. `wr_en`=0, `wr_addr`=`BASE_ADDR`, `wr_data`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0.
- Byte throughput: 1 byte per cycle in DATA. Each word costs 4 accept cycles plus 1 WRITE bubble, so 5 cycles per word at full rate.
- Latency: `wr_en` is asserted in the cycle immediately after the 4th byte's transfer edge. `wr_addr` and `wr_data` are stable only while `wr_en`=1.
- Bubbles (`in_valid`=0) pause assembly without losing partial bytes. `in_data` is sampled only on a transfer.
- DONE is entered the cycle after the last WRITE (no checksum) or after the checksum transfer. `load_done` and deasserted `cpu_hold` are visible from that cycle.
- `rst` mid-image: abort immediately. The partial word is discarded, no `wr_en` is issued in or after the reset cycle, and the loader returns to HDR. Words already written remain in memory.
- `rst` asserted during WRITE: `wr_en` is forced to 0 in that cycle (reset has priority).

## Configuration
- `LOADER_CHECKSUM_EN` defined: the CHK state exists. One trailing byte is required, equal to the XOR of all 4·N payload bytes. DONE is reached after it is accepted, and `load_err`=1 on mismatch. `cpu_hold` is released regardless; software or the bench checks `load_err`.
- Not defined: no CHK state, and DONE follows the final WRITE directly. `load_err` is tied to 0.

## Test plan
- N=1, bytes 01 02 03 04 at full rate -> one `wr_en` pulse with `wr_addr`=0x00000000 and `wr_data`=0x04030201. `cpu_hold` falls and `load_done` rises the following cycle (no checksum).
- N=3, payload with random `in_valid` gaps -> writes to 0x0, 0x4 and 0x8 with correct words. `in_ready`=0 exactly in each WRITE cycle. Exactly 3 `wr_en` pulses.
- Header 0x00, 1024 payload bytes -> 256 writes, last `wr_addr`=0x3FC. DONE is reached after write 256, with no extra write.
- `LOADER_CHECKSUM_EN`, N=1, payload 01 02 03 04, checksum 0x04 -> `load_err`=0. Repeat with checksum 0x05 -> `load_err`=1, `load_done`=1, `cpu_hold`=0.
- N=2, `rst` pulsed after 6 payload bytes -> only the first word is written. No write follows, the state returns to HDR, and a fresh image loads correctly.
- After DONE, hold `in_valid`=1 for 10 cycles -> `in_ready` stays 0, and there are no writes or output changes.
